// File: rtl/stim_sequencer_if.sv
// Schedule programming, playback control and button-drive bundle
// between the test controller and the stimulus sequencer.
interface stim_sequencer_if #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [CHANNELS-1:0] wr_mask;
    logic [CNT_W-1:0]    wr_width;
    logic [CNT_W-1:0]    wr_gap;
    logic                wr_last;
    logic                start;
    logic                loop;
    logic                abort;
    logic                busy;
    logic                done;
    logic [AW-1:0]       step;
    logic [CHANNELS-1:0] pulse_out;

    modport master (
        output wr_en, wr_addr, wr_mask, wr_width, wr_gap, wr_last,
        output start, loop, abort,
        input  busy, done, step, pulse_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_mask, wr_width, wr_gap, wr_last,
        input  start, loop, abort,
        output busy, done, step, pulse_out
    );
endinterface

// File: rtl/stim_sequencer.sv
// Replays a programmable schedule of active-low button pulses
// (mask, width, gap per step) onto the core's button inputs.
module stim_sequencer #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    stim_sequencer_if.slave sif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

    state_t              state;
    logic [CHANNELS-1:0] mask_q  [DEPTH];
    logic [CNT_W-1:0]    width_q [DEPTH];
    logic [CNT_W-1:0]    gap_q   [DEPTH];
    logic [DEPTH-1:0]    last_q;

    logic [CNT_W-1:0]    cnt;
    logic [AW-1:0]       step;
    logic                busy;
    logic                done;
    logic [CHANNELS-1:0] pulse_out;

    logic                wrap;
    logic                step_end;
    logic                load;
    logic [AW-1:0]       ld_idx;
    logic [CNT_W-1:0]    ld_w;

    // The schedule cannot change while busy, so entries are read in place.
    always_comb begin
        wrap     = last_q[step] || (step == AW'(DEPTH - 1));
        step_end = ((state == PULSE) && (cnt == '0) && (gap_q[step] == '0))
                || ((state == GAP) && (cnt == '0));
        load     = ((state == IDLE) && sif.start)
                || (step_end && (!wrap || sif.loop));
        ld_idx   = ((state == IDLE) || wrap) ? '0 : step + AW'(1);
        ld_w     = width_q[ld_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i]  <= '0;
                width_q[i] <= '0;
                gap_q[i]   <= '0;
            end
            last_q <= '0;
        end else if (sif.wr_en && ((state == IDLE) || (state == DONE))) begin
            mask_q[sif.wr_addr]  <= sif.wr_mask;
            width_q[sif.wr_addr] <= sif.wr_width;
            gap_q[sif.wr_addr]   <= sif.wr_gap;
            last_q[sif.wr_addr]  <= sif.wr_last;
        end
    end

    // Counters hold (cycles remaining - 1); a zero width still costs one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            step      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_out <= '1;
        end else if (sif.abort && busy) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pulse_out <= '1;
        end else if (load) begin
            state     <= PULSE;
            step      <= ld_idx;
            busy      <= 1'b1;
            done      <= 1'b0;
            cnt       <= (ld_w == '0) ? '0 : ld_w - CNT_W'(1);
            pulse_out <= (ld_w == '0) ? '1 : ~mask_q[ld_idx];
        end else if (step_end) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pulse_out <= '1;
        end else begin
            unique case (state)
                PULSE: begin
                    if (cnt == '0) begin
                        state     <= GAP;
                        cnt       <= gap_q[step] - CNT_W'(1);
                        pulse_out <= '1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP:  cnt <= cnt - CNT_W'(1);
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sif.busy      = busy;
    assign sif.done      = done;
    assign sif.step      = step;
    assign sif.pulse_out = pulse_out;
endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: schedule playback, looping,
// abort and write protection against hand-computed cycle traces.
module tb_stim_sequencer;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stim_sequencer_if #(
        .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) sif ();

    stim_sequencer #(
        .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sif  (sif)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [1:0] p,
                        input logic b, input logic d, input int s);
        chk({tag, " pulse"}, 32'(sif.pulse_out), 32'(p));
        chk({tag, " busy"},  32'(sif.busy),      32'(b));
        chk({tag, " done"},  32'(sif.done),      32'(d));
        chk({tag, " step"},  32'(sif.step),      32'(s));
    endtask

    task automatic wr(input int a, input logic [1:0] m, input int w,
                      input int g, input logic l);
        sif.wr_en    = 1'b1;
        sif.wr_addr  = 3'(a);
        sif.wr_mask  = m;
        sif.wr_width = 8'(w);
        sif.wr_gap   = 8'(g);
        sif.wr_last  = l;
        tick();
        sif.wr_en = 1'b0;
    endtask

    // Returns at the first cycle after the Start edge.
    task automatic go();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
    endtask

    // Entry0 = {01, w3, g2, last}: 3 low cycles, 2 gap, Done on cycle 6.
    task automatic play_single(input string tag);
        for (int c = 1; c <= 7; c++) begin
            if (c <= 3)      look(tag, 2'b10, 1'b1, 1'b0, 0);
            else if (c <= 5) look(tag, 2'b11, 1'b1, 1'b0, 0);
            else if (c == 6) look(tag, 2'b11, 1'b0, 1'b1, 0);
            else             look(tag, 2'b11, 1'b0, 1'b0, 0);
            if (c < 7) tick();
        end
    endtask

    initial begin
        logic [1:0] p;
        int k;
        int off;

        sif.wr_en = 0; sif.wr_addr = 0; sif.wr_mask = 0;
        sif.wr_width = 0; sif.wr_gap = 0; sif.wr_last = 0;
        sif.start = 0; sif.loop = 0; sif.abort = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            look("reset_idle", 2'b11, 1'b0, 1'b0, 0);
            tick();
        end

        wr(0, 2'b01, 3, 2, 1'b1);
        go();
        play_single("single");
        tick();

        wr(0, 2'b10, 1, 10, 1'b0);
        wr(1, 2'b01, 1, 10, 1'b0);
        wr(2, 2'b01, 1, 10, 1'b0);
        wr(3, 2'b01, 1, 10, 1'b1);
        go();
        for (int c = 1; c <= 44; c++) begin
            k   = (c - 1) / 11;
            off = (c - 1) % 11;
            if (off != 0)    p = 2'b11;
            else if (k == 0) p = 2'b01;
            else             p = 2'b10;
            look("runcont", p, 1'b1, 1'b0, k);
            tick();
        end
        look("runcont_done", 2'b11, 1'b0, 1'b1, 3);
        tick();
        look("runcont_idle", 2'b11, 1'b0, 1'b0, 3);
        tick();

        wr(0, 2'b01, 3, 2, 1'b1);
        go();
        look("wrbusy_c1", 2'b10, 1'b1, 1'b0, 0);
        wr(0, 2'b10, 9, 9, 1'b0);
        look("wrbusy_c2", 2'b10, 1'b1, 1'b0, 0);
        for (int c = 0; c < 6; c++) tick();
        sif.start = 1'b1;
        tick();
        play_single("replay");
        sif.start = 1'b0;
        tick();
        look("start_ignored", 2'b11, 1'b0, 1'b0, 0);
        tick();

        wr(0, 2'b01, 2, 0, 1'b0);
        wr(1, 2'b10, 200, 0, 1'b1);
        go();
        for (int c = 1; c <= 50; c++) begin
            if (c <= 2) look("abort_run", 2'b10, 1'b1, 1'b0, 0);
            else        look("abort_run", 2'b01, 1'b1, 1'b0, 1);
            if (c < 50) tick();
        end
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
        for (int c = 51; c <= 60; c++) begin
            look("abort_hold", 2'b11, 1'b0, 1'b0, 1);
            tick();
        end

        for (int i = 0; i < DEPTH; i++) wr(i, 2'b01, 1, 0, 1'b0);
        sif.loop = 1'b1;
        go();
        for (int c = 1; c <= 20; c++) begin
            look("loop", 2'b10, 1'b1, 1'b0, (c - 1) % 8);
            if (c < 20) tick();
        end
        sif.loop = 1'b0;
        tick();
        for (int c = 21; c <= 24; c++) begin
            look("unloop", 2'b10, 1'b1, 1'b0, c - 17);
            tick();
        end
        look("unloop_done", 2'b11, 1'b0, 1'b1, 7);
        tick();
        look("unloop_idle", 2'b11, 1'b0, 1'b0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
